// File: rtl/hdc_pkg.sv
// Shared types and constants for the HDC seizure-detection classifier path.
package hdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    POST  = 2'd3
  } sched_state_t;

  localparam logic LBL_NONSEIZURE = 1'b0;
  localparam logic LBL_SEIZURE    = 1'b1;

endpackage

// File: rtl/sim_scheduler_label_smoother.sv
// Onset/offset debounce of per-window labels into a stable seizure alarm.
module label_smoother
  import hdc_pkg::*;
#(
  parameter int unsigned ONSET_K  = 3,
  parameter int unsigned OFFSET_K = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic upd,
  input  logic lbl,
  output logic alarm
);

  localparam int unsigned ON_W  = $clog2(ONSET_K + 1);
  localparam int unsigned OFF_W = $clog2(OFFSET_K + 1);

  logic [ON_W-1:0]  r_seiz_run, w_seiz_nxt;
  logic [OFF_W-1:0] r_non_run,  w_non_nxt;
  logic             r_alarm;

  // Run counters saturate so a long run keeps the threshold condition true.
  always_comb begin
    w_seiz_nxt = (r_seiz_run == ON_W'(ONSET_K)) ? r_seiz_run : r_seiz_run + ON_W'(1);
    w_non_nxt  = (r_non_run == OFF_W'(OFFSET_K)) ? r_non_run : r_non_run + OFF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_seiz_run <= '0;
      r_non_run  <= '0;
      r_alarm    <= 1'b0;
    end else if (upd) begin
      if (lbl == LBL_SEIZURE) begin
        r_seiz_run <= w_seiz_nxt;
        r_non_run  <= '0;
        if (w_seiz_nxt == ON_W'(ONSET_K)) r_alarm <= 1'b1;
      end else begin
        r_non_run  <= w_non_nxt;
        r_seiz_run <= '0;
        if (w_non_nxt == OFF_W'(OFFSET_K)) r_alarm <= 1'b0;
      end
    end
  end

  assign alarm = r_alarm;

endmodule

// File: rtl/sim_scheduler.sv
// Sequences one similarity lookup per accepted hypervector, with timeout,
// window counting and debounced alarm generation.
module sim_scheduler
  import hdc_pkg::*;
#(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned ONSET_K    = 3,
  parameter int unsigned OFFSET_K   = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  flush,
  output logic                  sim_en,
  output logic [DIMENSIONS-1:0] sim_hv_test,
  input  logic                  sim_done,
  input  logic                  sim_label,
  output logic                  out_valid,
  output logic                  out_label,
  output logic                  alarm,
  output logic [CNT_W-1:0]      win_cnt,
  output logic                  timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  sched_state_t          r_state;
  logic [DIMENSIONS-1:0] r_hv;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_out_label;
  logic                  r_to_err;
  logic [CNT_W-1:0]      r_win_cnt;
  logic                  w_post;

  assign w_post = (r_state == POST);

  // sim_done is only looked at in WAIT, so late responses after a reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hv        <= '0;
      r_to_cnt    <= '0;
      r_out_label <= LBL_NONSEIZURE;
      r_to_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_hv    <= in_hv;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (sim_done) begin
            r_out_label <= sim_label;
            r_state     <= POST;
          end else if (r_to_cnt == TO_W'(TIMEOUT)) begin
            r_to_err    <= 1'b1;
            r_out_label <= LBL_NONSEIZURE;
            r_state     <= POST;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        POST:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) r_win_cnt <= '0;
    else if (w_post)  r_win_cnt <= r_win_cnt + CNT_W'(1);
  end

  label_smoother #(
    .ONSET_K (ONSET_K),
    .OFFSET_K(OFFSET_K)
  ) u_smoother (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .upd  (w_post),
    .lbl  (r_out_label),
    .alarm(alarm)
  );

  assign in_ready    = (r_state == IDLE);
  assign sim_en      = (r_state == ISSUE);
  assign out_valid   = w_post;
  assign sim_hv_test = r_hv;
  assign out_label   = r_out_label;
  assign win_cnt     = r_win_cnt;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_sim_scheduler.sv
// Directed bench for sim_scheduler with a nearest-prototype similarity stand-in
// (prototypes 5'b00000 / 5'b11111, configurable done latency, optional stuck done).
module tb_sim_scheduler;

  localparam int unsigned DIM     = 5;
  localparam int unsigned TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, flush;
  logic [DIM-1:0] in_hv, sim_hv_test;
  logic           sim_en, sim_done, sim_label;
  logic           out_valid, out_label, alarm, timeout_err;
  logic [15:0]    win_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int   lat_cfg = 2;
  logic stub    = 1'b0;
  int   m_cnt   = 0;
  logic m_lbl   = 1'b0;
  int   en_pulses = 0;

  always #5 clk = ~clk;

  sim_scheduler #(
    .DIMENSIONS(DIM),
    .TIMEOUT   (TIMEOUT),
    .ONSET_K   (2),
    .OFFSET_K  (2),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_hv      (in_hv),
    .flush      (flush),
    .sim_en     (sim_en),
    .sim_hv_test(sim_hv_test),
    .sim_done   (sim_done),
    .sim_label  (sim_label),
    .out_valid  (out_valid),
    .out_label  (out_label),
    .alarm      (alarm),
    .win_cnt    (win_cnt),
    .timeout_err(timeout_err)
  );

  // Similarity stand-in: done rises lat_cfg cycles after en; label = closer prototype.
  always @(posedge clk) begin
    if (sim_en === 1'b1) begin
      m_cnt     <= lat_cfg;
      m_lbl     <= ($countones(sim_hv_test) >= 3);
      en_pulses <= en_pulses + 1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign sim_done  = !stub && (m_cnt == 1);
  assign sim_label = m_lbl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_win(input logic [DIM-1:0] hv, input int lat, input logic stub_i,
                          input logic noise, input logic do_flush, input logic exp_lbl,
                          input logic exp_alarm, input int exp_win, input logic exp_err);
    int   n;
    int   exp_n;
    logic seen;
    lat_cfg = lat;
    stub    = stub_i;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_hv    = hv;
    @(negedge clk);
    check("sim_en", sim_en, 1);
    check("hv_test", sim_hv_test, hv);
    check("ready_busy", in_ready, 0);
    if (noise) in_hv = DIM'($urandom);
    else       in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check("no_extra_en", sim_en, 0);
      check("ready_wait", in_ready, 0);
      if (noise) begin
        check("hv_hold", sim_hv_test, hv);
        in_hv = DIM'($urandom);
      end
    end
    in_valid = 1'b0;
    exp_n = stub_i ? int'(TIMEOUT) + 2 : lat + 1;
    check("out_valid", seen, 1);
    check("latency", n, exp_n);
    check("out_label", out_label, exp_lbl);
    check("ready_post", in_ready, 0);
    if (do_flush) flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("valid_1cyc", out_valid, 0);
    check("alarm", alarm, exp_alarm);
    check("win_cnt", win_cnt, exp_win);
    check("timeout_err", timeout_err, exp_err);
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    int   n;
    logic bad;
    rst = 1'b1; in_valid = 1'b0; in_hv = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_en", sim_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_label", out_label, 0);
    check("rst_alarm", alarm, 0);
    check("rst_win", win_cnt, 0);
    check("rst_err", timeout_err, 0);
    check("rst_hv", sim_hv_test, 0);
    rst = 1'b0;
    @(negedge clk);

    //        hv        lat stub noise flush lbl alarm win err
    send_win(5'b00001, 1, 0, 0, 0, 0, 0, 1, 0);
    send_win(5'b11010, 2, 0, 0, 0, 1, 0, 2, 0);
    send_win(5'b11111, 3, 0, 0, 0, 1, 1, 3, 0);
    send_win(5'b00101, 2, 0, 0, 0, 0, 1, 4, 0);
    send_win(5'b11100, 5, 0, 0, 0, 1, 1, 5, 0);
    send_win(5'b00000, 1, 0, 0, 0, 0, 1, 6, 0);
    send_win(5'b00011, 2, 0, 0, 0, 0, 0, 7, 0);
    send_win(5'b10110, 4, 0, 1, 0, 1, 0, 8, 0);
    send_win(5'b11111, 2, 1, 0, 0, 0, 0, 9, 1);
    send_win(5'b11111, 2, 0, 0, 0, 1, 0, 10, 1);
    send_win(5'b11111, 1, 0, 0, 0, 1, 1, 11, 1);
    send_win(5'b01111, 3, 0, 0, 1, 1, 0, 0, 1);
    send_win(5'b11111, 2, 0, 0, 0, 1, 0, 1, 1);

    // Reset while WAITing; the stand-in still raises done later, which must be ignored.
    lat_cfg = 10;
    stub    = 1'b0;
    in_valid = 1'b1;
    in_hv    = 5'b11111;
    @(negedge clk);
    check("abort_en", sim_en, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_label", out_label, 0);
    check("abort_alarm", alarm, 0);
    check("abort_win", win_cnt, 0);
    check("abort_err", timeout_err, 0);
    check("abort_hv", sim_hv_test, 0);
    bad = 1'b0;
    for (n = 0; n < 14; n++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || sim_en !== 1'b0) bad = 1'b1;
    end
    check("abort_quiet", bad, 0);

    send_win(5'b00000, 2, 0, 0, 0, 0, 0, 1, 0);
    check("en_pulses", en_pulses, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
